// File: rtl/fifo_occ_pkg.sv
// fifo_occ_pkg
//   Shared definitions for the fifo_occ_ctl FIFO:
//   - FIFO_DEF_DEPTH / FIFO_DEF_WIDTH : default geometry
//   - fifo_op_e                       : accepted-operation encoding for one cycle
//                                       (bit 0 = push accepted, bit 1 = pop accepted)
//   - clog2_count(depth)              : width needed to hold a count 0..depth
package fifo_occ_pkg;

  localparam int FIFO_DEF_DEPTH = 16;
  localparam int FIFO_DEF_WIDTH = 8;

  typedef enum logic [1:0] {
    FIFO_OP_IDLE = 2'd0,
    FIFO_OP_PUSH = 2'd1,
    FIFO_OP_POP  = 2'd2,
    FIFO_OP_BOTH = 2'd3
  } fifo_op_e;

  // Bits needed to represent 0..depth (i.e. clog2(depth+1)).
  function automatic int clog2_count(input int depth);
    int w;
    w = 0;
    for (int i = 0; i < 31; i++) begin
      if ((64'd1 << i) <= 64'(depth)) begin
        w = i + 1;
      end
    end
    return w;
  endfunction

endpackage

// File: rtl/fifo_occ_mem.sv
// fifo_occ_mem
//   DEPTH x WIDTH register array, one write port and one synchronous read port.
//   The storage itself is not reset; only the read data register is, so that
//   the FIFO read output starts at zero.
// Ports:
//   clk    : clock
//   reset  : synchronous active-high reset of the read data register
//   we     : write enable, waddr/wdata written on the clock edge
//   waddr  : write address
//   wdata  : write data
//   re     : read enable, rdata <= mem[raddr] on the clock edge, else holds
//   raddr  : read address
//   rdata  : registered read data
module fifo_occ_mem #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [WIDTH-1:0] rdata_r;

  // Storage write port.
  always_ff @(posedge clk) begin
    if (we) begin
      mem_r[waddr] <= wdata;
    end
  end

  // Registered read port; holds the last word when no read is requested.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_r <= '0;
    end else if (re) begin
      rdata_r <= mem_r[raddr];
    end else begin
      rdata_r <= rdata_r;
    end
  end

  assign rdata = rdata_r;

endmodule

// File: rtl/fifo_occ_ctl.sv
// fifo_occ_ctl
//   Synchronous FIFO with occupancy count, almost-full/almost-empty flags and
//   sticky overflow/underflow error flags.
// Ports:
//   clk, reset          : clock, synchronous active-high reset
//   push, data_in       : write request and data
//   pop                 : read request
//   data_out, rd_valid  : read data, valid one cycle after an accepted pop
//   fifo_count          : occupancy 0..DEPTH
//   full, empty         : fifo_count==DEPTH / fifo_count==0
//   almost_full         : fifo_count >= AF_LEVEL
//   almost_empty        : fifo_count <= AE_LEVEL
//   overflow_err        : sticky, set by a dropped push
//   underflow_err       : sticky, set by a rejected pop
//   err_clr             : clears both error flags (a same-cycle new error wins)
module fifo_occ_ctl
  import fifo_occ_pkg::*;
#(
  parameter  int WIDTH    = FIFO_DEF_WIDTH,
  parameter  int DEPTH    = FIFO_DEF_DEPTH,
  parameter  int AF_LEVEL = 12,
  parameter  int AE_LEVEL = 4,
  localparam int CW       = clog2_count(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] data_in,
  input  logic             pop,
  output logic [WIDTH-1:0] data_out,
  output logic             rd_valid,
  output logic [CW-1:0]    fifo_count,
  output logic             full,
  output logic             empty,
  output logic             almost_full,
  output logic             almost_empty,
  output logic             overflow_err,
  output logic             underflow_err,
  input  logic             err_clr
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);
  localparam logic [CW-1:0] AF_C    = CW'(AF_LEVEL);
  localparam logic [CW-1:0] AE_C    = CW'(AE_LEVEL);
  localparam logic [CW-1:0] CNT_ONE = CW'(1'b1);
  localparam logic [AW-1:0] PTR_LAST = AW'(DEPTH - 1);
  localparam logic [AW-1:0] PTR_ONE  = AW'(1'b1);

  logic [AW-1:0] wr_ptr_r;
  logic [AW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;
  logic          rd_valid_r;
  logic          overflow_r;
  logic          underflow_r;

  logic          full_s;
  logic          empty_s;
  logic          push_ok_s;
  logic          pop_ok_s;
  logic          ovf_set_s;
  logic          unf_set_s;
  fifo_op_e      op_s;
  logic [CW-1:0] count_nxt_s;

  // Explicit wrap so non-power-of-two depths work.
  function automatic logic [AW-1:0] ptr_next(input logic [AW-1:0] p);
    if (p == PTR_LAST) begin
      return '0;
    end else begin
      return p + PTR_ONE;
    end
  endfunction

  assign full_s  = (count_r == DEPTH_C);
  assign empty_s = (count_r == '0);

  // A pop makes room, so a push into a full FIFO is accepted alongside it.
  assign pop_ok_s  = pop & ~empty_s;
  assign push_ok_s = push & (~full_s | pop_ok_s);
  assign ovf_set_s = push & full_s & ~pop;
  assign unf_set_s = pop & empty_s;
  assign op_s      = fifo_op_e'({pop_ok_s, push_ok_s});

  // Next occupancy from the accepted operation pair.
  always_comb begin
    count_nxt_s = count_r;
    case (op_s)
      FIFO_OP_PUSH: count_nxt_s = count_r + CNT_ONE;
      FIFO_OP_POP:  count_nxt_s = count_r - CNT_ONE;
      FIFO_OP_IDLE: count_nxt_s = count_r;
      FIFO_OP_BOTH: count_nxt_s = count_r;
      default:      count_nxt_s = count_r;
    endcase
  end

  // Pointers, occupancy and read-valid pulse.
  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr_r   <= '0;
      rd_ptr_r   <= '0;
      count_r    <= '0;
      rd_valid_r <= 1'b0;
    end else begin
      wr_ptr_r   <= push_ok_s ? ptr_next(wr_ptr_r) : wr_ptr_r;
      rd_ptr_r   <= pop_ok_s  ? ptr_next(rd_ptr_r) : rd_ptr_r;
      count_r    <= count_nxt_s;
      rd_valid_r <= pop_ok_s;
    end
  end

  // Sticky error flags; a new error in the clear cycle keeps the flag set.
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow_r  <= 1'b0;
      underflow_r <= 1'b0;
    end else begin
      if (ovf_set_s) begin
        overflow_r <= 1'b1;
      end else if (err_clr) begin
        overflow_r <= 1'b0;
      end else begin
        overflow_r <= overflow_r;
      end
      if (unf_set_s) begin
        underflow_r <= 1'b1;
      end else if (err_clr) begin
        underflow_r <= 1'b0;
      end else begin
        underflow_r <= underflow_r;
      end
    end
  end

  fifo_occ_mem #(
    .WIDTH (WIDTH),
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_mem (
    .clk   (clk),
    .reset (reset),
    .we    (push_ok_s),
    .waddr (wr_ptr_r),
    .wdata (data_in),
    .re    (pop_ok_s),
    .raddr (rd_ptr_r),
    .rdata (data_out)
  );

  assign rd_valid      = rd_valid_r;
  assign fifo_count    = count_r;
  assign full          = full_s;
  assign empty         = empty_s;
  assign almost_full   = (count_r >= AF_C);
  assign almost_empty  = (count_r <= AE_C);
  assign overflow_err  = overflow_r;
  assign underflow_err = underflow_r;

endmodule

// File: tb/tb_fifo_occ_ctl.sv
// tb_fifo_occ_ctl
//   Self-checking bench for fifo_occ_ctl: a DEPTH=16 instance driven by a
//   queue-based reference model with a read-data scoreboard plus a table of
//   hand-computed vectors, and a DEPTH=5 instance for non-power-of-two wrap.
module tb_fifo_occ_ctl;
  import fifo_occ_pkg::*;

  localparam int D  = 16;
  localparam int AF = 12;
  localparam int AE = 4;
  localparam int D5 = 5;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  // DEPTH=16 instance
  logic       reset, push, pop, err_clr;
  logic [7:0] data_in, data_out;
  logic       rd_valid, full, empty, almost_full, almost_empty;
  logic       overflow_err, underflow_err;
  logic [4:0] fifo_count;

  fifo_occ_ctl #(.WIDTH(8), .DEPTH(D), .AF_LEVEL(AF), .AE_LEVEL(AE)) dut (
    .clk(clk), .reset(reset), .push(push), .data_in(data_in), .pop(pop),
    .data_out(data_out), .rd_valid(rd_valid), .fifo_count(fifo_count),
    .full(full), .empty(empty), .almost_full(almost_full),
    .almost_empty(almost_empty), .overflow_err(overflow_err),
    .underflow_err(underflow_err), .err_clr(err_clr)
  );

  // DEPTH=5 instance
  logic       reset5, push5, pop5, err_clr5;
  logic [7:0] data_in5, data_out5;
  logic       rd_valid5, full5, empty5, almost_full5, almost_empty5;
  logic       overflow_err5, underflow_err5;
  logic [2:0] fifo_count5;

  fifo_occ_ctl #(.WIDTH(8), .DEPTH(D5), .AF_LEVEL(4), .AE_LEVEL(1)) dut5 (
    .clk(clk), .reset(reset5), .push(push5), .data_in(data_in5), .pop(pop5),
    .data_out(data_out5), .rd_valid(rd_valid5), .fifo_count(fifo_count5),
    .full(full5), .empty(empty5), .almost_full(almost_full5),
    .almost_empty(almost_empty5), .overflow_err(overflow_err5),
    .underflow_err(underflow_err5), .err_clr(err_clr5)
  );

  int n_chk  = 0;
  int n_fail = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual=0x%0h required=0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model state for the DEPTH=16 instance
  logic [7:0] mq[$];
  logic [7:0] sb_q[$];
  logic       m_rv, m_ovf, m_unf;
  logic [7:0] m_data;
  int         cov[4];

  // One clock of stimulus on the DEPTH=16 instance, then full comparison.
  task automatic step(input logic p, input logic q, input logic [7:0] d,
                      input logic c, input logic r);
    int cnt;
    logic f, e, pok, puok;
    logic [7:0] exp_d;
    push = p; pop = q; data_in = d; err_clr = c; reset = r;
    cnt  = mq.size();
    f    = (cnt == D);
    e    = (cnt == 0);
    pok  = q && !e;
    puok = p && (!f || pok);
    if (r) begin
      mq.delete(); sb_q.delete();
      m_rv = 1'b0; m_data = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;
    end else begin
      cov[int'({pok, puok})]++;
      if (pok) sb_q.push_back(mq.pop_front());
      m_rv = pok;
      if (puok) mq.push_back(d);
      if (p && f && !q) m_ovf = 1'b1; else if (c) m_ovf = 1'b0;
      if (q && e)       m_unf = 1'b1; else if (c) m_unf = 1'b0;
    end
    @(posedge clk); #1;
    cnt = mq.size();
    chk("count",         fifo_count,    cnt);
    chk("full",          full,          cnt == D);
    chk("empty",         empty,         cnt == 0);
    chk("almost_full",   almost_full,   cnt >= AF);
    chk("almost_empty",  almost_empty,  cnt <= AE);
    chk("overflow_err",  overflow_err,  m_ovf);
    chk("underflow_err", underflow_err, m_unf);
    chk("rd_valid",      rd_valid,      m_rv);
    if (rd_valid === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("rd_valid_unexpected", sb_q.size(), 1);
      end else begin
        exp_d = sb_q.pop_front();
        chk("data_out", data_out, exp_d);
        m_data = exp_d;
      end
    end else begin
      chk("data_hold", data_out, m_data);
    end
  endtask

  // Model and stepping for the DEPTH=5 instance
  logic [7:0] mq5[$];
  logic [7:0] m5_data;

  task automatic step5(input logic p, input logic q, input logic [7:0] d, input logic r);
    int cnt;
    logic pok, puok, rv;
    push5 = p; pop5 = q; data_in5 = d; reset5 = r; err_clr5 = 1'b0;
    cnt  = mq5.size();
    pok  = q && (cnt != 0);
    puok = p && ((cnt != D5) || pok);
    rv   = 1'b0;
    if (r) begin
      mq5.delete(); m5_data = 8'h00;
    end else begin
      if (pok) begin m5_data = mq5.pop_front(); rv = 1'b1; end
      if (puok) mq5.push_back(d);
    end
    @(posedge clk); #1;
    cnt = mq5.size();
    chk("d5_count",        fifo_count5,    cnt);
    chk("d5_full",         full5,          cnt == D5);
    chk("d5_empty",        empty5,         cnt == 0);
    chk("d5_almost_full",  almost_full5,   cnt >= 4);
    chk("d5_almost_empty", almost_empty5,  cnt <= 1);
    chk("d5_rd_valid",     rd_valid5,      rv);
    chk("d5_data_out",     data_out5,      m5_data);
    chk("d5_errs",         {overflow_err5, underflow_err5}, 2'b00);
  endtask

  typedef struct {
    logic       push;
    logic       pop;
    logic       clr;
    logic [7:0] din;
    int         e_cnt;
    logic       e_rv;
    logic [7:0] e_data;
    logic       e_unf;
  } vec_t;

  vec_t vt[8];

  initial begin
    push = 1'b0; pop = 1'b0; data_in = 8'h00; err_clr = 1'b0; reset = 1'b1;
    push5 = 1'b0; pop5 = 1'b0; data_in5 = 8'h00; err_clr5 = 1'b0; reset5 = 1'b1;
    m_rv = 1'b0; m_ovf = 1'b0; m_unf = 1'b0; m_data = 8'h00;
    m5_data = 8'h00;
    for (int i = 0; i < 4; i++) cov[i] = 0;

    // Underflow, empty push+pop, then ordinary traffic; hand-computed results.
    //          push  pop   clr   din    cnt rv    data   unf
    vt[0] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b0, 8'h00, 1'b1};
    vt[1] = '{1'b1, 1'b1, 1'b0, 8'h5C, 1, 1'b0, 8'h00, 1'b1};
    vt[2] = '{1'b0, 1'b1, 1'b0, 8'h00, 0, 1'b1, 8'h5C, 1'b1};
    vt[3] = '{1'b0, 1'b0, 1'b1, 8'h00, 0, 1'b0, 8'h5C, 1'b0};
    vt[4] = '{1'b1, 1'b0, 1'b0, 8'h11, 1, 1'b0, 8'h5C, 1'b0};
    vt[5] = '{1'b1, 1'b0, 1'b0, 8'h22, 2, 1'b0, 8'h5C, 1'b0};
    vt[6] = '{1'b1, 1'b1, 1'b0, 8'h33, 2, 1'b1, 8'h11, 1'b0};
    vt[7] = '{1'b0, 1'b0, 1'b0, 8'h00, 2, 1'b0, 8'h11, 1'b0};

    // Reset state
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b1);
    chk("reset_empty", empty, 1'b1);
    chk("reset_almost_full", almost_full, 1'b0);

    for (int i = 0; i < 8; i++) begin
      step(vt[i].push, vt[i].pop, vt[i].din, vt[i].clr, 1'b0);
      chk($sformatf("vec%0d_count", i),    fifo_count,    vt[i].e_cnt);
      chk($sformatf("vec%0d_rd_valid", i), rd_valid,      vt[i].e_rv);
      chk($sformatf("vec%0d_data", i),     data_out,      vt[i].e_data);
      chk($sformatf("vec%0d_underflow", i), underflow_err, vt[i].e_unf);
    end

    // Fill 0x00..0x0F
    step(1'b0, 1'b0, 8'h00, 1'b0, 1'b1);
    for (int i = 0; i < D; i++) begin
      step(1'b1, 1'b0, 8'(i), 1'b0, 1'b0);
      if (i == 4)  chk("ae_at_5",  almost_empty, 1'b0);
      if (i == 11) chk("af_at_12", almost_full,  1'b1);
    end
    chk("fill_full", full, 1'b1);

    // Overflow, clear, then set/clear collision
    step(1'b1, 1'b0, 8'hAA, 1'b0, 1'b0);
    chk("ovf_count", fifo_count, D);
    chk("ovf_set", overflow_err, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);
    chk("ovf_clear", overflow_err, 1'b0);
    step(1'b1, 1'b0, 8'hBB, 1'b1, 1'b0);
    chk("ovf_set_wins", overflow_err, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1, 1'b0);

    // Full push+pop across several wraps
    for (int i = 0; i < 40; i++) begin
      step(1'b1, 1'b1, 8'(16 + i), 1'b0, 1'b0);
      chk("wrap_full", full, 1'b1);
    end

    // Drain; dropped words must never appear
    for (int i = 0; i < D; i++) begin
      step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
      if (rd_valid === 1'b1) chk("no_dropped_word", (data_out == 8'hAA) || (data_out == 8'hBB), 1'b0);
    end
    chk("drain_empty", empty, 1'b1);

    // Reset mid-stream with a pop on the reset edge
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 8'(8'h60 + i), 1'b0, 1'b0);
    chk("pre_reset_count", fifo_count, 7);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b1);
    chk("mid_reset_rd_valid", rd_valid, 1'b0);
    chk("mid_reset_count", fifo_count, 0);
    step(1'b1, 1'b0, 8'h33, 1'b0, 1'b0);
    step(1'b0, 1'b1, 8'h00, 1'b0, 1'b0);
    chk("post_reset_data", data_out, 8'h33);
    chk("post_reset_valid", rd_valid, 1'b1);

    chk("cov_push", cov[FIFO_OP_PUSH] > 0, 1'b1);
    chk("cov_pop",  cov[FIFO_OP_POP]  > 0, 1'b1);
    chk("cov_both", cov[FIFO_OP_BOTH] > 0, 1'b1);
    chk("sb_drained", sb_q.size(), 0);

    // DEPTH=5: fill, 12 cycles of push+pop, drain
    step5(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < D5; i++) step5(1'b1, 1'b0, 8'(i), 1'b0);
    for (int i = 0; i < 12; i++) begin
      step5(1'b1, 1'b1, 8'(D5 + i), 1'b0);
      chk("d5_wrap_data", data_out5, 8'(i));
    end
    for (int i = 0; i < D5; i++) begin
      step5(1'b0, 1'b1, 8'h00, 1'b0);
      chk("d5_drain_data", data_out5, 8'(12 + i));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  // Guard against a stuck run.
  initial begin
    #100000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1);
  end

endmodule
